// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encodings and defaults for the fetch sequencer
package fetch_ctrl_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FC_IDLE = 2'd0,
        FC_REQ  = 2'd1,
        FC_HOLD = 2'd2,
        FC_KILL = 2'd3
    } fc_state_t;

    // Cycles without imem_ack before a fetch error (timeout build only)
    localparam int FC_TIMEOUT = 16;
    // Width of the timeout counter; must hold FC_TIMEOUT
    localparam int FC_TO_W    = 5;

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: imem request, decode handshake, PC write enable
//
// Optional feature macro: FETCH_TIMEOUT_EN (fetch timeout counter and fetch_err pulse).
//
// Ports:
//   clk         clock, rising edge
//   rest        asynchronous active-high reset
//   pc_addr     current PC value
//   imem_req    instruction fetch request
//   imem_addr   fetch address (pc_addr, or the pre-redirect address while killing)
//   imem_ack    memory done, imem_rdata valid this cycle
//   imem_rdata  fetched word
//   inst_valid  inst holds a valid instruction for decode
//   inst        registered instruction word
//   inst_ready  decode consumes inst this cycle
//   redirect    control unit applies a non-sequential pc_op this cycle
//   pc_en       PC register write enable (one-cycle pulse)
//   fetch_err   one-cycle pulse on fetch timeout (0 unless FETCH_TIMEOUT_EN)
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT = FC_TIMEOUT,
    parameter int TO_W    = FC_TO_W
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] pc_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    input  logic        inst_ready,
    input  logic        redirect,
    output logic        pc_en,
    output logic        fetch_err
);

    fc_state_t   state;
    logic [31:0] kill_addr;

    // Once redirected, pc_addr already points at the target, so the
    // in-flight request keeps the address captured at redirect time.
    assign imem_addr = (state == FC_KILL) ? kill_addr : pc_addr;

    // PC advances when decode accepts or control redirects; a redirect and an
    // accept in the same HOLD cycle collapse into one pulse. Decoded from the
    // state register so an asynchronous reset clears it immediately.
    assign pc_en = ((state == FC_HOLD) && (inst_ready || redirect)) ||
                   ((state == FC_REQ)  && redirect);

`ifdef FETCH_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    logic            kill_entry;
    logic            to_hit;

    // A redirect without ack in REQ starts a new (KILL) wait window.
    assign kill_entry = (state == FC_REQ) && redirect && !imem_ack;
    // Last waiting cycle: the counter would reach TIMEOUT at this edge.
    assign to_hit     = imem_req && !imem_ack && !kill_entry && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= to_hit;
            // Idle/hold keep it at zero, so every entry to REQ starts clean.
            if (!imem_req || imem_ack || kill_entry || to_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state      <= FC_IDLE;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            kill_addr  <= '0;
        end else begin
            case (state)
                FC_IDLE: begin
                    state      <= FC_REQ;
                    imem_req   <= 1'b1;
                    inst_valid <= 1'b0;
                end
                FC_REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            // Word belongs to the abandoned path: drop it and
                            // fetch the redirect target next.
                            state <= FC_REQ;
                        end else begin
                            inst       <= imem_rdata;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= FC_HOLD;
                        end
                    end else if (redirect) begin
                        kill_addr <= pc_addr;
                        state     <= FC_KILL;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (to_hit) begin
                        imem_req <= 1'b0;
                        state    <= FC_IDLE;
                    end
`endif
                end
                FC_HOLD: begin
                    if (inst_ready || redirect) begin
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= FC_REQ;
                    end
                end
                FC_KILL: begin
                    // Redirects are ignored here; only the ack matters.
                    if (imem_ack) begin
                        state <= FC_REQ;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (to_hit) begin
                        imem_req <= 1'b0;
                        state    <= FC_IDLE;
                    end
`endif
                end
                default: begin
                    state      <= FC_IDLE;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] pc_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        redirect;
    logic        pc_en;
    logic        fetch_err;

    logic [31:0] redirect_target;
    int          n_cmp = 0;
    int          n_err = 0;
    int          ack_delay;
    int          req_cnt;
    bit          force_ack;

    logic        s_req, s_valid, s_pc_en, s_err, s_ack;
    logic [31:0] s_inst, s_addr, s_pc;

    always #5 clk = ~clk;

    fetch_ctrl #(.TIMEOUT(4), .TO_W(5)) dut (
        .clk        (clk),
        .rest       (rest),
        .pc_addr    (pc_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .pc_en      (pc_en),
        .fetch_err  (fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h9fc00000) return 32'h3c1d0001;
        return {a[15:0], a[31:16]} ^ 32'hc0de0bad;
    endfunction

    // One clock: memory answers at the negedge, outputs are sampled, then the
    // PC model (pc register behaviour) updates just after the rising edge.
    task automatic cyc();
        logic [31:0] next_pc;
        @(negedge clk);
        imem_ack   = force_ack || (imem_req && (req_cnt >= ack_delay));
        imem_rdata = mem_word(imem_addr);
        #1;
        s_req   = imem_req;
        s_valid = inst_valid;
        s_pc_en = pc_en;
        s_err   = fetch_err;
        s_ack   = imem_ack;
        s_inst  = inst;
        s_addr  = imem_addr;
        s_pc    = pc_addr;
        next_pc = pc_en ? (redirect ? redirect_target : pc_addr + 32'd4) : pc_addr;
        if (imem_req && !imem_ack) req_cnt++;
        else req_cnt = 0;
        @(posedge clk);
        #1;
        pc_addr = next_pc;
    endtask

    task automatic do_reset(input logic [31:0] a);
        rest = 1'b1;
        redirect = 1'b0;
        inst_ready = 1'b0;
        force_ack = 1'b0;
        imem_ack = 1'b0;
        req_cnt = 0;
        pc_addr = a;
        @(posedge clk);
        #1;
        rest = 1'b0;
    endtask

    task automatic test_reset();
        int req_first, valid_first, pulses;
        logic [31:0] vinst, addr5;
        rest = 1'b1;
        #2;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h expected 0", inst); end
        n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL reset_pc_en: got %b expected 0", pc_en); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
        do_reset(32'h9fc00000);
        ack_delay = 2;
        inst_ready = 1'b1;
        req_first = -1; valid_first = -1; pulses = 0; vinst = '0; addr5 = '0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (s_req && req_first < 0) req_first = i;
            if (s_valid && valid_first < 0) begin valid_first = i; vinst = s_inst; end
            if (s_pc_en) pulses++;
            if (i == 5) addr5 = s_addr;
        end
        n_cmp++; if (req_first != 1) begin n_err++; $display("FAIL first_req_cycle: got %0d expected 1", req_first); end
        n_cmp++; if (valid_first != 4) begin n_err++; $display("FAIL first_valid_cycle: got %0d expected 4", valid_first); end
        n_cmp++; if (vinst !== 32'h3c1d0001) begin n_err++; $display("FAIL first_inst: got %h expected 3c1d0001", vinst); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL first_pc_en_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (addr5 !== 32'h9fc00004) begin n_err++; $display("FAIL second_req_addr: got %h expected 9fc00004", addr5); end
    endtask

    task automatic test_comb_ack();
        do_reset(32'h00400000);
        ack_delay = 0;
        cyc();
        n_cmp++; if (s_req !== 1'b0) begin n_err++; $display("FAIL comb_idle_req: got %b expected 0", s_req); end
        cyc();
        n_cmp++; if (s_req !== 1'b1 || s_valid !== 1'b0) begin n_err++; $display("FAIL comb_req: got req=%b valid=%b expected req=1 valid=0", s_req, s_valid); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (s_valid !== 1'b1 || s_pc_en !== 1'b0) begin n_err++; $display("FAIL comb_hold%0d: got valid=%b pc_en=%b expected 1/0", i, s_valid, s_pc_en); end
            n_cmp++; if (s_inst !== mem_word(32'h00400000)) begin n_err++; $display("FAIL comb_inst%0d: got %h expected %h", i, s_inst, mem_word(32'h00400000)); end
        end
        inst_ready = 1'b1;
        cyc();
        n_cmp++; if (s_pc_en !== 1'b1) begin n_err++; $display("FAIL comb_accept_pc_en: got %b expected 1", s_pc_en); end
        inst_ready = 1'b0;
        cyc();
        n_cmp++; if (s_req !== 1'b1 || s_valid !== 1'b0 || s_addr !== 32'h00400004) begin n_err++; $display("FAIL comb_next_req: got req=%b valid=%b addr=%h expected 1/0/00400004", s_req, s_valid, s_addr); end
        cyc();
        n_cmp++; if (s_valid !== 1'b1 || s_inst !== mem_word(32'h00400004)) begin n_err++; $display("FAIL comb_next_inst: got valid=%b inst=%h expected 1/%h", s_valid, s_inst, mem_word(32'h00400004)); end
    endtask

    task automatic test_redirect_req();
        bit found;
        do_reset(32'hbfc00100);
        ack_delay = 2;
        inst_ready = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (s_req !== 1'b1 || s_pc_en !== 1'b0) begin n_err++; $display("FAIL rq_req0: got req=%b pc_en=%b expected 1/0", s_req, s_pc_en); end
        redirect = 1'b1;
        redirect_target = 32'h80000180;
        cyc();
        n_cmp++; if (s_pc_en !== 1'b1) begin n_err++; $display("FAIL rq_redirect_pc_en: got %b expected 1", s_pc_en); end
        redirect_target = 32'h00001234;
        cyc();
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00100 || s_ack !== 1'b1) begin n_err++; $display("FAIL rq_kill_hold_addr: got req=%b addr=%h ack=%b expected 1/bfc00100/1", s_req, s_addr, s_ack); end
        n_cmp++; if (s_pc_en !== 1'b0 || s_valid !== 1'b0) begin n_err++; $display("FAIL rq_kill_ignored: got pc_en=%b valid=%b expected 0/0", s_pc_en, s_valid); end
        redirect = 1'b0;
        cyc();
        n_cmp++; if (s_req !== 1'b1 || s_valid !== 1'b0 || s_addr !== 32'h80000180) begin n_err++; $display("FAIL rq_new_req: got req=%b valid=%b addr=%h expected 1/0/80000180", s_req, s_valid, s_addr); end
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc();
            if (s_valid) found = 1;
        end
        n_cmp++; if (!found || s_inst !== mem_word(32'h80000180)) begin n_err++; $display("FAIL rq_target_inst: got found=%0d inst=%h expected 1/%h", found, s_inst, mem_word(32'h80000180)); end
        ack_delay = 0;
        redirect = 1'b1;
        redirect_target = 32'h00001000;
        inst_ready = 1'b0;
        cyc();
        n_cmp++; if (s_req !== 1'b1 || s_ack !== 1'b1 || s_pc_en !== 1'b1) begin n_err++; $display("FAIL rq_ack_redirect: got req=%b ack=%b pc_en=%b expected 1/1/1", s_req, s_ack, s_pc_en); end
        redirect = 1'b0;
        cyc();
        n_cmp++; if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h00001000) begin n_err++; $display("FAIL rq_dropped_word: got valid=%b req=%b addr=%h expected 0/1/00001000", s_valid, s_req, s_addr); end
        cyc();
        n_cmp++; if (s_valid !== 1'b1 || s_inst !== mem_word(32'h00001000)) begin n_err++; $display("FAIL rq_after_drop_inst: got valid=%b inst=%h expected 1/%h", s_valid, s_inst, mem_word(32'h00001000)); end
    endtask

    task automatic test_redirect_and_ready();
        bit found;
        do_reset(32'h00400100);
        ack_delay = 1;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc();
            if (s_valid) found = 1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL rr_reach_hold: got valid=0 expected 1"); end
        inst_ready = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h00400800;
        cyc();
        n_cmp++; if (s_pc_en !== 1'b1) begin n_err++; $display("FAIL rr_pc_en: got %b expected 1", s_pc_en); end
        inst_ready = 1'b0;
        redirect = 1'b0;
        cyc();
        n_cmp++; if (s_pc_en !== 1'b0 || s_valid !== 1'b0) begin n_err++; $display("FAIL rr_single_pulse: got pc_en=%b valid=%b expected 0/0", s_pc_en, s_valid); end
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h00400800) begin n_err++; $display("FAIL rr_target_req: got req=%b addr=%h expected 1/00400800", s_req, s_addr); end
    endtask

    task automatic test_async_reset();
        do_reset(32'h00400200);
        ack_delay = 100;
        cyc();
        cyc();
        redirect = 1'b1;
        redirect_target = 32'h00400900;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || pc_en !== 1'b1) begin n_err++; $display("FAIL ar_pre: got req=%b pc_en=%b expected 1/1", imem_req, pc_en); end
        #1;
        rest = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || pc_en !== 1'b0 || inst_valid !== 1'b0) begin n_err++; $display("FAIL ar_async: got req=%b pc_en=%b valid=%b expected 0/0/0", imem_req, pc_en, inst_valid); end
        redirect = 1'b0;
        @(posedge clk);
        #1;
        rest = 1'b0;
        req_cnt = 0;
        force_ack = 1'b1;
        cyc();
        n_cmp++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin n_err++; $display("FAIL ar_idle: got req=%b valid=%b expected 0/0", s_req, s_valid); end
        force_ack = 1'b0;
        cyc();
        n_cmp++; if (s_valid !== 1'b0 || s_req !== 1'b1) begin n_err++; $display("FAIL ar_late_ack1: got valid=%b req=%b expected 0/1", s_valid, s_req); end
        cyc();
        n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL ar_late_ack2: got valid=%b expected 0", s_valid); end
    endtask

    task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
        int reqs;
        bit found;
        do_reset(32'h00400300);
        ack_delay = 1000;
        cyc();
        reqs = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (s_err) found = 1;
            else if (s_req) reqs++;
        end
        n_cmp++; if (!found || reqs != 4) begin n_err++; $display("FAIL to_pulse: got found=%0d reqs=%0d expected 1/4", found, reqs); end
        n_cmp++; if (s_req !== 1'b0) begin n_err++; $display("FAIL to_idle_req: got %b expected 0", s_req); end
        cyc();
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h00400300 || s_err !== 1'b0) begin n_err++; $display("FAIL to_retry: got req=%b addr=%h err=%b expected 1/00400300/0", s_req, s_addr, s_err); end
`else
        int errs, lows;
        do_reset(32'h00400300);
        ack_delay = 1000;
        cyc();
        errs = 0;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (s_err) errs++;
            if (!s_req) lows++;
        end
        n_cmp++; if (errs != 0) begin n_err++; $display("FAIL nto_err: got %0d pulses expected 0", errs); end
        n_cmp++; if (lows != 0) begin n_err++; $display("FAIL nto_req_drop: got %0d low cycles expected 0", lows); end
`endif
    endtask

    task automatic test_random();
        logic exp_pc_en;
        logic prev_pc_en;
        int accepted;
        do_reset($urandom & 32'h00fffffc);
        prev_pc_en = 1'b0;
        accepted = 0;
        for (int i = 0; i < 400; i++) begin
            if (req_cnt == 0) ack_delay = $urandom_range(0, 3);
            inst_ready = 1'($urandom_range(0, 1));
            redirect = inst_valid && ($urandom_range(0, 4) == 0);
            redirect_target = $urandom & 32'hfffffffc;
            exp_pc_en = inst_valid && (inst_ready || redirect);
            cyc();
            n_cmp++; if (s_pc_en !== exp_pc_en) begin n_err++; $display("FAIL rnd_pc_en@%0d: got %b expected %b", i, s_pc_en, exp_pc_en); end
            if (s_pc_en && prev_pc_en) begin n_cmp++; n_err++; $display("FAIL rnd_pc_en_back_to_back@%0d: got 2 cycles expected 1", i); end
            if (s_valid) begin
                n_cmp++; if (s_inst !== mem_word(s_pc)) begin n_err++; $display("FAIL rnd_inst@%0d: got %h expected %h", i, s_inst, mem_word(s_pc)); end
            end
            if (s_req) begin
                n_cmp++; if (s_addr !== s_pc) begin n_err++; $display("FAIL rnd_addr@%0d: got %h expected %h", i, s_addr, s_pc); end
            end
            if (s_valid && s_pc_en) accepted++;
            prev_pc_en = s_pc_en;
        end
        inst_ready = 1'b0;
        redirect = 1'b0;
        n_cmp++; if (accepted < 20) begin n_err++; $display("FAIL rnd_progress: got %0d accepted expected >= 20", accepted); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rest = 1'b1;
        pc_addr = 32'h9fc00000;
        imem_ack = 1'b0;
        imem_rdata = '0;
        inst_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        force_ack = 1'b0;
        ack_delay = 0;
        req_cnt = 0;
        test_reset();
        test_comb_ack();
        test_redirect_req();
        test_redirect_and_ready();
        test_async_reset();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
